// File: rtl/error_counter.sv
// rtl/error_counter.sv - phase-strobed signed error counter with synchronised plus/minus commands
module error_counter #(
  parameter int WIDTH       = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    FAZ2HI,
  input  logic                    FAZ4HI,
  input  logic                    EEC,
  input  logic                    ECPLS,
  input  logic                    ECMNS,
  output logic signed [WIDTH-1:0] ECNT,
  output logic                    ECZERO,
  output logic                    ECSAT,
  output logic                    ECACK
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam logic signed [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] CNT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                   state;
  logic [SYNC_STAGES-1:0]   pls_sync, mns_sync;
  logic                     pls_prev, mns_prev;
  logic                     faz2_prev, faz4_prev;
  logic                     pend_pls, pend_mns;
  logic                     samp_pls, samp_mns;
  logic                     ack_pend;

  logic                     pls_edge, mns_edge, faz2_rise, faz4_rise;
  logic signed [WIDTH-1:0]  cnt_next;
  logic                     sat_set, applied;

  assign pls_edge  = pls_sync[SYNC_STAGES-1] & ~pls_prev;
  assign mns_edge  = mns_sync[SYNC_STAGES-1] & ~mns_prev;
  assign faz2_rise = FAZ2HI & ~faz2_prev;
  assign faz4_rise = FAZ4HI & ~faz4_prev;

  // Only an exclusive plus or minus sample moves the count; a step past a limit is dropped.
  always_comb begin
    cnt_next = ECNT;
    sat_set  = 1'b0;
    applied  = 1'b0;
    if (!EEC) begin
      cnt_next = '0;
    end else if (state == RUN && faz4_rise && (samp_pls ^ samp_mns)) begin
      if (samp_pls) begin
        if (ECNT == CNT_MAX) sat_set = 1'b1;
        else begin
          cnt_next = ECNT + CNT_ONE;
          applied  = 1'b1;
        end
      end else begin
        if (ECNT == CNT_MIN) sat_set = 1'b1;
        else begin
          cnt_next = ECNT - CNT_ONE;
          applied  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pls_sync  <= '0;
      mns_sync  <= '0;
      pls_prev  <= 1'b0;
      mns_prev  <= 1'b0;
      faz2_prev <= 1'b0;
      faz4_prev <= 1'b0;
      pend_pls  <= 1'b0;
      pend_mns  <= 1'b0;
      samp_pls  <= 1'b0;
      samp_mns  <= 1'b0;
      ack_pend  <= 1'b0;
      ECNT      <= '0;
      ECZERO    <= 1'b1;
      ECSAT     <= 1'b0;
      ECACK     <= 1'b0;
    end else begin
      pls_sync  <= SYNC_STAGES'({pls_sync, ECPLS});
      mns_sync  <= SYNC_STAGES'({mns_sync, ECMNS});
      pls_prev  <= pls_sync[SYNC_STAGES-1];
      mns_prev  <= mns_sync[SYNC_STAGES-1];
      faz2_prev <= FAZ2HI;
      faz4_prev <= FAZ4HI;
      ECNT      <= cnt_next;
      ECZERO    <= (cnt_next == '0);
      ack_pend  <= applied;
      ECACK     <= ack_pend;
      if (!EEC) begin
        state    <= IDLE;
        pend_pls <= 1'b0;
        pend_mns <= 1'b0;
        samp_pls <= 1'b0;
        samp_mns <= 1'b0;
        ECSAT    <= 1'b0;
      end else begin
        if (sat_set) ECSAT <= 1'b1;
        case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            if (faz2_rise) begin
              // An edge landing on the sample strobe stays pending for the next cycle.
              samp_pls <= pend_pls;
              samp_mns <= pend_mns;
              pend_pls <= pls_edge;
              pend_mns <= mns_edge;
              state    <= RUN;
            end else begin
              pend_pls <= pend_pls | pls_edge;
              pend_mns <= pend_mns | mns_edge;
            end
          end
          RUN: begin
            pend_pls <= pend_pls | pls_edge;
            pend_mns <= pend_mns | mns_edge;
            if (faz4_rise) begin
              samp_pls <= 1'b0;
              samp_mns <= 1'b0;
              state    <= ARMED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_error_counter.sv
// tb/tb_error_counter.sv - table and scoreboard bench for error_counter
module tb_error_counter;

  localparam int W    = 9;
  localparam int CMAX = (1 << (W-1)) - 1;
  localparam int CMIN = -(1 << (W-1));

  logic                 clk = 1'b0;
  logic                 rst, FAZ2HI, FAZ4HI, EEC, ECPLS, ECMNS;
  logic signed [W-1:0]  ECNT;
  logic                 ECZERO, ECSAT, ECACK;

  error_counter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .FAZ2HI(FAZ2HI), .FAZ4HI(FAZ4HI), .EEC(EEC),
    .ECPLS(ECPLS), .ECMNS(ECMNS), .ECNT(ECNT), .ECZERO(ECZERO),
    .ECSAT(ECSAT), .ECACK(ECACK)
  );

  always #5 clk = ~clk;

  typedef struct { int cnt; int acks; int sat; } exp_t;
  typedef struct { bit p; bit m; int reps; int exp_cnt; int exp_ack; } vec_t;

  exp_t sb[$];
  int   tests = 0, fails = 0, ack_cnt = 0;
  int   m_cnt = 0, m_sat = 0;

  always @(negedge clk) if (ECACK === 1'b1) ack_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives reps command pulses then one FAZ2/FAZ4 cycle; the model predicts the result.
  task automatic do_phase(input bit p, input bit m, input int reps, input string name);
    exp_t e;
    int   a0;
    e.acks = 0;
    if (!EEC) begin
      m_cnt = 0; m_sat = 0;
    end else if (reps > 0 && (p ^ m)) begin
      if (p) begin
        if (m_cnt == CMAX) m_sat = 1; else begin m_cnt++; e.acks = 1; end
      end else begin
        if (m_cnt == CMIN) m_sat = 1; else begin m_cnt--; e.acks = 1; end
      end
    end
    e.cnt = m_cnt; e.sat = m_sat;
    sb.push_back(e);
    a0 = ack_cnt;
    repeat (reps) begin
      ECPLS = p; ECMNS = m; tick(3);
      ECPLS = 0; ECMNS = 0; tick(3);
    end
    FAZ2HI = 1; tick(1); FAZ2HI = 0; tick(1);
    FAZ4HI = 1; tick(1); FAZ4HI = 0; tick(3);
    e = sb.pop_front();
    check({name, " cnt"}, int'(ECNT), e.cnt);
    check({name, " ack"}, ack_cnt - a0, e.acks);
    check({name, " sat"}, int'(ECSAT), e.sat);
    check({name, " zero"}, int'(ECZERO), int'(e.cnt == 0));
  endtask

  initial begin
    vec_t tbl[10];
    int   a0;
    tbl[0] = '{1, 0, 1,  1, 1};
    tbl[1] = '{1, 0, 1,  2, 1};
    tbl[2] = '{1, 0, 1,  3, 1};
    tbl[3] = '{1, 1, 1,  3, 0};
    tbl[4] = '{0, 0, 0,  3, 0};
    tbl[5] = '{0, 1, 1,  2, 1};
    tbl[6] = '{0, 1, 1,  1, 1};
    tbl[7] = '{0, 1, 1,  0, 1};
    tbl[8] = '{0, 1, 1, -1, 1};
    tbl[9] = '{1, 0, 2,  0, 1};

    rst = 1; FAZ2HI = 0; FAZ4HI = 0; EEC = 0; ECPLS = 0; ECMNS = 0;
    tick(3);
    check("rst cnt",  int'(ECNT), 0);
    check("rst zero", int'(ECZERO), 1);
    check("rst sat",  int'(ECSAT), 0);
    check("rst ack",  int'(ECACK), 0);
    rst = 0;
    EEC = 1; tick(2);

    for (int i = 0; i < 10; i++) begin
      a0 = ack_cnt;
      do_phase(tbl[i].p, tbl[i].m, tbl[i].reps, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d const cnt", i), int'(ECNT), tbl[i].exp_cnt);
      check($sformatf("tbl%0d const ack", i), ack_cnt - a0, tbl[i].exp_ack);
    end

    for (int i = 0; i < 260; i++) do_phase(1, 0, 1, "satp");
    check("sat hi cnt", int'(ECNT), CMAX);
    check("sat hi flag", int'(ECSAT), 1);
    do_phase(0, 1, 1, "satm");
    check("sat back cnt", int'(ECNT), CMAX - 1);
    check("sat sticky", int'(ECSAT), 1);

    EEC = 0; tick(1); m_cnt = 0; m_sat = 0;
    EEC = 1; tick(2);
    for (int i = 0; i < 5; i++) do_phase(1, 0, 1, "five");
    check("five cnt", int'(ECNT), 5);
    EEC = 0; tick(1);
    check("idle cnt",  int'(ECNT), 0);
    check("idle zero", int'(ECZERO), 1);
    check("idle sat",  int'(ECSAT), 0);
    do_phase(1, 0, 1, "idle pls");

    EEC = 1; tick(2);
    a0 = ack_cnt;
    ECPLS = 1; tick(3); ECPLS = 0; tick(3);
    FAZ2HI = 1; tick(1); FAZ2HI = 0; tick(1);
    rst = 1; tick(1); rst = 0; tick(2);
    FAZ4HI = 1; tick(1); FAZ4HI = 0; tick(4);
    check("rst run cnt",  int'(ECNT), 0);
    check("rst run ack",  ack_cnt - a0, 0);
    check("rst run zero", int'(ECZERO), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/error_counter.md
ERROR_COUNTER -- requirements
Module: error_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 9, the counter width in bits (two's complement).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchroniser depth on the command pulse inputs.
REQ-003 SHALL provide port clk, input, 1, the single system clock on which all state updates occur.
REQ-004 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port FAZ2HI, input, 1, phase-2 level from the phase generator; its rising edge is the sample strobe.
REQ-006 SHALL provide port FAZ4HI, input, 1, phase-4 level from the phase generator; its rising edge is the update strobe.
REQ-007 SHALL provide port EEC, input, 1, error-counter enable level (AEEC/BEEC/CEEC from the phase generator).
REQ-008 SHALL provide port ECPLS, input, 1, asynchronous plus command pulse from the computer.
REQ-009 SHALL provide port ECMNS, input, 1, asynchronous minus command pulse from the computer.
REQ-010 SHALL provide port ECNT, output, WIDTH, current signed count for the DAC.
REQ-011 SHALL provide port ECZERO, output, 1, high when ECNT == 0.
REQ-012 SHALL provide port ECSAT, output, 1, sticky saturation flag.
REQ-013 SHALL provide port ECACK, output, 1, one-clk pulse marking each applied count.

Function
REQ-014 SHALL pass ECPLS and ECMNS through SYNC_STAGES flops each, then rising-edge detect them.
REQ-015 SHALL set a pending-plus flag on each detected ECPLS edge and a pending-minus flag on each detected ECMNS edge; a second edge on the same line before service is dropped.
REQ-016 SHALL operate in three states: IDLE (EEC low), ARMED (EEC high, no sample taken), RUN (sample latched, awaiting update).
REQ-017 SHALL move IDLE->ARMED on the first clk with synchronised EEC high; any state->IDLE on EEC low.
REQ-018 SHALL, in ARMED, on a FAZ2HI rising edge copy the pending flags into a sample register, clear the pending flags, and enter RUN.
REQ-019 SHALL, in RUN, on a FAZ4HI rising edge apply the sample, clear it, and return to ARMED: plus only -> +1, minus only -> -1, both or neither -> no change.
REQ-020 SHALL limit count changes to at most one per FAZ2/FAZ4 cycle.
REQ-021 SHALL saturate at +(2^(WIDTH-1))-1 and -(2^(WIDTH-1)); a count that would pass a limit is discarded and sets ECSAT.
REQ-022 SHALL pulse ECACK for exactly one clk, on the cycle after ECNT changes; no pulse on a discarded, cancelled or empty update.
REQ-023 SHALL, in IDLE, hold ECNT = 0 and all pending/sample flags cleared, and ignore command edges.
REQ-024 SHALL clear ECSAT only on entry to IDLE or on reset.
REQ-025 SHALL ignore a FAZ4HI edge in ARMED and a FAZ2HI edge in RUN.
REQ-026 SHALL register ECZERO from the next-state count so it is coincident with ECNT.
REQ-027 SHALL, if an edge is detected on the same clk as the FAZ2HI sample strobe, service it in the next cycle.

Reset
REQ-028 SHALL, with rst high at a clk edge, set state IDLE, ECNT = 0, ECZERO = 1, ECSAT = 0, ECACK = 0, and clear synchroniser, pending and sample registers.
REQ-029 SHALL, on rst asserted mid-RUN, discard the sample with no ECACK.

Verification
REQ-030 SHALL cover: EEC high, 3 ECPLS pulses in separate phase cycles -> ECNT = 3, three ECACK pulses, ECZERO 0.
REQ-031 SHALL cover: ECPLS and ECMNS in the same cycle -> ECNT unchanged, no ECACK.
REQ-032 SHALL cover: WIDTH = 9, 260 ECPLS pulses -> ECNT = 255, ECSAT = 1; one ECMNS -> ECNT = 254, ECSAT stays 1.
REQ-033 SHALL cover: ECNT = 5, then EEC low -> next clk ECNT = 0, ECZERO = 1, ECSAT = 0; ECPLS while EEC low -> no change.
REQ-034 SHALL cover: two ECPLS edges before one FAZ2HI edge -> ECNT +1 only.
REQ-035 SHALL cover: rst between FAZ2HI and FAZ4HI with a sampled plus -> ECNT = 0, no ECACK after rst released.
